// File: rtl/bg_mem_arb.sv
// Background memory arbiter: the display owns the single-port memory outside blanking,
// the loader gets bounded bursts inside blanking. Optional stats: BG_MEM_ARB_STATS_EN.
module bg_mem_arb #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_TOTAL   = 1344,
    parameter int V_ACTIVE  = 768,
    parameter int V_TOTAL   = 806,
    parameter int GUARD     = 4,
    parameter int MAX_BURST = 64,
    parameter int AW        = 20,
    parameter int DW        = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   hcount_in,
    input  logic [10:0]   vcount_in,
    input  logic          vsync_in,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          conflict
`ifdef BG_MEM_ARB_STATS_EN
    ,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   xfer_cnt
`endif
);

    typedef enum logic [1:0] {DISP, LOAD, HOLD} state_t;
    localparam int BW = $clog2(MAX_BURST + 1);

    function automatic logic in_window(input logic [10:0] h, input logic [10:0] v);
        int hi;
        int vi;
        hi = int'(h);
        vi = int'(v);
        return (hi >= H_ACTIVE && hi < H_TOTAL - GUARD) ||
               (vi >= V_ACTIVE && vi < V_TOTAL - 1) ||
               (vi == V_TOTAL - 1 && hi < H_TOTAL - GUARD);
    endfunction

    state_t        state_reg;
    logic          gnt_reg;
    logic [BW-1:0] burst_reg;
    logic          rvalid_reg;
    logic [DW-1:0] rdata_reg;
    logic [DW-1:0] disp_rdata_reg;
    logic          conflict_reg;

    logic [10:0] hcount_next;
    logic        win_open;
    logic        win_next;
    logic        ld_own;
    logic        xfer;
    logic        rd_xfer;
    logic        burst_last;

    assign hcount_next = (int'(hcount_in) == H_TOTAL - 1) ? 11'd0 : hcount_in + 11'd1;
    assign win_open    = in_window(hcount_in, vcount_in);
    assign win_next    = in_window(hcount_next, vcount_in);

    // A stale grant outside the window never reaches the memory: display wins.
    assign ld_own     = gnt_reg && win_open;
    assign xfer       = ld_own && ld_req;
    assign rd_xfer    = xfer && !ld_we;
    assign burst_last = (int'(burst_reg) + 1) >= MAX_BURST;

    assign mem_addr  = ld_own ? ld_addr : disp_addr;
    assign mem_we    = xfer && ld_we;
    assign mem_wdata = ld_wdata;

    assign ld_gnt     = gnt_reg;
    assign ld_rvalid  = rvalid_reg;
    assign ld_rdata   = rdata_reg;
    assign disp_rdata = disp_rdata_reg;
    assign conflict   = conflict_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= DISP;
            gnt_reg        <= 1'b0;
            burst_reg      <= '0;
            rvalid_reg     <= 1'b0;
            rdata_reg      <= '0;
            disp_rdata_reg <= '0;
            conflict_reg   <= 1'b0;
        end else begin
            rvalid_reg <= rd_xfer;
            if (rd_xfer) begin
                rdata_reg <= mem_rdata;
            end
            disp_rdata_reg <= ld_own ? '0 : mem_rdata;
            if (gnt_reg && !win_open) begin
                conflict_reg <= 1'b1;
            end

            case (state_reg)
                DISP: begin
                    if (win_next && ld_req) begin
                        state_reg <= LOAD;
                        gnt_reg   <= 1'b1;
                    end
                end
                LOAD: begin
                    // Window end (or an illegal grant) dominates the burst limit.
                    if (!win_open || !win_next || !ld_req) begin
                        state_reg <= DISP;
                        gnt_reg   <= 1'b0;
                        burst_reg <= '0;
                    end else begin
                        burst_reg <= burst_reg + BW'(1);
                        if (burst_last) begin
                            state_reg <= HOLD;
                            gnt_reg   <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!win_open) begin
                        state_reg <= DISP;
                        burst_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= DISP;
                    gnt_reg   <= 1'b0;
                    burst_reg <= '0;
                end
            endcase
        end
    end

`ifdef BG_MEM_ARB_STATS_EN
    logic        vsync_d_reg;
    logic [15:0] stall_run_reg;
    logic [15:0] xfer_run_reg;
    logic [15:0] stall_snap_reg;
    logic [15:0] xfer_snap_reg;

    assign stall_cnt = stall_snap_reg;
    assign xfer_cnt  = xfer_snap_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d_reg    <= 1'b0;
            stall_run_reg  <= '0;
            xfer_run_reg   <= '0;
            stall_snap_reg <= '0;
            xfer_snap_reg  <= '0;
        end else begin
            vsync_d_reg <= vsync_in;
            if (vsync_in && !vsync_d_reg) begin
                stall_snap_reg <= stall_run_reg;
                xfer_snap_reg  <= xfer_run_reg;
                stall_run_reg  <= '0;
                xfer_run_reg   <= '0;
            end else begin
                if (ld_req && !gnt_reg && stall_run_reg != 16'hFFFF) begin
                    stall_run_reg <= stall_run_reg + 16'd1;
                end
                if (xfer && xfer_run_reg != 16'hFFFF) begin
                    xfer_run_reg <= xfer_run_reg + 16'd1;
                end
            end
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = vsync_in;
`endif

endmodule

// File: tb/tb_bg_mem_arb.sv
// Bench for bg_mem_arb: directed table, corner sequences and random traffic checked
// against a window/burst model, on a default instance and a MAX_BURST=4 instance.
module tb_bg_mem_arb;
    localparam int AW = 20;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [10:0]   hcount = 11'd0;
    logic [10:0]   vcount = 11'd0;
    logic          vsync = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [AW-1:0] ld_addr = '0;
    logic          ld_req = 1'b0;
    logic          ld_we = 1'b0;
    logic [DW-1:0] ld_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;

    logic          gnt_o [2];
    logic          rv_o  [2];
    logic          we_o  [2];
    logic          conf_o[2];
    logic [DW-1:0] rd_o  [2];
    logic [DW-1:0] disp_o[2];
    logic [DW-1:0] wd_o  [2];
    logic [AW-1:0] ma_o  [2];
`ifdef BG_MEM_ARB_STATS_EN
    logic [15:0]   st_o[2];
    logic [15:0]   xc_o[2];
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bg_mem_arb u_dut0 (
        .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount), .vsync_in(vsync),
        .disp_addr(disp_addr), .disp_rdata(disp_o[0]), .ld_req(ld_req), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(gnt_o[0]), .ld_rvalid(rv_o[0]),
        .ld_rdata(rd_o[0]), .mem_addr(ma_o[0]), .mem_we(we_o[0]), .mem_wdata(wd_o[0]),
        .mem_rdata(mem_rdata), .conflict(conf_o[0])
`ifdef BG_MEM_ARB_STATS_EN
        , .stall_cnt(st_o[0]), .xfer_cnt(xc_o[0])
`endif
    );

    bg_mem_arb #(.MAX_BURST(4)) u_dut1 (
        .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount), .vsync_in(vsync),
        .disp_addr(disp_addr), .disp_rdata(disp_o[1]), .ld_req(ld_req), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(gnt_o[1]), .ld_rvalid(rv_o[1]),
        .ld_rdata(rd_o[1]), .mem_addr(ma_o[1]), .mem_we(we_o[1]), .mem_wdata(wd_o[1]),
        .mem_rdata(mem_rdata), .conflict(conf_o[1])
`ifdef BG_MEM_ARB_STATS_EN
        , .stall_cnt(st_o[1]), .xfer_cnt(xc_o[1])
`endif
    );

    // Reference model: a grant session per blanking window, a transfer tally, and an
    // "exhausted" flag that blocks regrant until the window has closed.
    bit            m_ok = 1'b0;
    bit            m_g   [2];
    bit            m_exh [2];
    bit            m_conf[2];
    bit            m_rv  [2];
    int            m_cnt [2];
    logic [DW-1:0] m_rd  [2];
    logic [DW-1:0] m_disp[2];
    int            maxb  [2] = '{64, 4};

    function automatic bit win(input int h, input int v);
        return (h >= 1024 && h < 1340) || (v >= 768 && v < 805) || (v == 805 && h < 1340);
    endfunction

    function automatic int hnext(input int h);
        return (h == 1343) ? 0 : h + 1;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d h=%0d v=%0d got=%h want=%h t=%0t",
                     name, k, hcount, vcount, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit own;
        if (!m_ok) return;
        for (int k = 0; k < 2; k++) begin
            own = m_g[k] && win(int'(hcount), int'(vcount));
            check("gnt", k, 32'(gnt_o[k]), 32'(m_g[k]));
            check("rvalid", k, 32'(rv_o[k]), 32'(m_rv[k]));
            check("rdata", k, 32'(rd_o[k]), 32'(m_rd[k]));
            check("disp_rdata", k, 32'(disp_o[k]), 32'(m_disp[k]));
            check("conflict", k, 32'(conf_o[k]), 32'(m_conf[k]));
            check("mem_we", k, 32'(we_o[k]), 32'(own && ld_req && ld_we));
            check("mem_addr", k, 32'(ma_o[k]), 32'(own ? ld_addr : disp_addr));
            if (own) check("mem_wdata", k, 32'(wd_o[k]), 32'(ld_wdata));
        end
    endtask

    task automatic model_step(input int k);
        bit wo, wn, own, xf;
        if (rst) begin
            m_g[k] = 0; m_exh[k] = 0; m_conf[k] = 0; m_rv[k] = 0;
            m_cnt[k] = 0; m_rd[k] = '0; m_disp[k] = '0;
            return;
        end
        wo  = win(int'(hcount), int'(vcount));
        wn  = win(hnext(int'(hcount)), int'(vcount));
        own = m_g[k] && wo;
        xf  = own && ld_req;
        m_rv[k] = xf && !ld_we;
        if (m_rv[k]) m_rd[k] = mem_rdata;
        m_disp[k] = own ? '0 : mem_rdata;
        if (m_g[k] && !wo) m_conf[k] = 1;
        if (m_g[k]) begin
            if (xf) m_cnt[k]++;
            if (!wo || !wn || !ld_req) begin
                m_g[k] = 0; m_cnt[k] = 0;
            end else if (m_cnt[k] >= maxb[k]) begin
                m_g[k] = 0; m_exh[k] = 1;
            end
        end else if (m_exh[k]) begin
            if (!wo) begin m_exh[k] = 0; m_cnt[k] = 0; end
        end else if (wn && ld_req) begin
            m_g[k] = 1;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        compare_all();
    endtask

    task automatic at_pos();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        m_ok = 1'b1;
        #1;
    endtask

    task automatic step();
        at_neg();
        at_pos();
    endtask

    task automatic set_in(input int h, input int v, input bit req, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] mrd);
        hcount = 11'(h); vcount = 11'(v); ld_req = req; ld_we = we;
        ld_addr = a; ld_wdata = wd; mem_rdata = mrd;
    endtask

    typedef struct {
        int            h;
        bit            req;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] mrd;
        bit            e_gnt;
        bit            e_we;
        bit            e_rv;
        logic [DW-1:0] e_rd;
        bit            c_disp;
        logic [DW-1:0] e_disp;
    } vec_t;

    vec_t tbl[11];
    int   xcount[2];

    initial begin
        // h-blank entry, write, read return, request drop, window close (v=100)
        tbl[0]  = '{100,  1, 1, 20'h00010, 12'h5A5, 12'hABC, 0, 0, 0, 12'h000, 0, 12'h000};
        tbl[1]  = '{101,  1, 1, 20'h00010, 12'h5A5, 12'h000, 0, 0, 0, 12'h000, 1, 12'hABC};
        tbl[2]  = '{1023, 1, 1, 20'h00010, 12'h5A5, 12'h000, 0, 0, 0, 12'h000, 0, 12'h000};
        tbl[3]  = '{1024, 1, 1, 20'h00010, 12'h5A5, 12'h111, 1, 1, 0, 12'h000, 1, 12'h000};
        tbl[4]  = '{1025, 1, 0, 20'h00020, 12'h000, 12'h123, 1, 0, 0, 12'h000, 1, 12'h000};
        tbl[5]  = '{1026, 0, 0, 20'h00020, 12'h000, 12'h777, 1, 0, 1, 12'h123, 1, 12'h000};
        tbl[6]  = '{1027, 1, 1, 20'h00030, 12'h3C3, 12'h000, 0, 0, 0, 12'h000, 1, 12'h000};
        tbl[7]  = '{1028, 1, 1, 20'h00031, 12'h3C4, 12'h000, 1, 1, 0, 12'h000, 0, 12'h000};
        tbl[8]  = '{1339, 1, 1, 20'h00032, 12'h3C5, 12'h000, 1, 1, 0, 12'h000, 0, 12'h000};
        tbl[9]  = '{1340, 1, 1, 20'h00033, 12'h3C6, 12'h456, 0, 0, 0, 12'h000, 0, 12'h000};
        tbl[10] = '{1341, 1, 1, 20'h00034, 12'h3C7, 12'h000, 0, 0, 0, 12'h000, 1, 12'h456};

        // Reset held 3 cycles with a pending request mid-blank.
        disp_addr = 20'h12345;
        set_in(1100, 100, 1, 1, 20'h00010, 12'h5A5, 12'h000);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            if (i > 0) begin
                check("rst_gnt", 0, 32'(gnt_o[0]), 32'd0);
                check("rst_rvalid", 0, 32'(rv_o[0]), 32'd0);
                check("rst_conflict", 0, 32'(conf_o[0]), 32'd0);
                check("rst_mem_we", 0, 32'(we_o[0]), 32'd0);
            end
            at_pos();
        end
        rst = 1'b0;
        at_neg();
        check("post_rst_gnt0", 0, 32'(gnt_o[0]), 32'd0);
        at_pos();
        at_neg();
        check("post_rst_gnt1", 0, 32'(gnt_o[0]), 32'd1);
        at_pos();

        // Illegal grant: jump into active video while granted.
        set_in(200, 100, 1, 1, 20'h00040, 12'h0F0, 12'h000);
        at_neg();
        check("cfl_mem_we", 0, 32'(we_o[0]), 32'd0);
        check("cfl_mem_addr", 0, 32'(ma_o[0]), 32'(disp_addr));
        at_pos();
        at_neg();
        check("cfl_set", 0, 32'(conf_o[0]), 32'd1);
        check("cfl_gnt", 0, 32'(gnt_o[0]), 32'd0);
        at_pos();
        repeat (3) step();
        at_neg();
        check("cfl_sticky", 0, 32'(conf_o[0]), 32'd1);
        at_pos();
        rst = 1'b1; step(); rst = 1'b0;
        at_neg();
        check("cfl_clear", 0, 32'(conf_o[0]), 32'd0);
        at_pos();

        // Directed table on the default instance.
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].h, 100, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].mrd);
            at_neg();
            check("tbl_gnt", i, 32'(gnt_o[0]), 32'(tbl[i].e_gnt));
            check("tbl_mem_we", i, 32'(we_o[0]), 32'(tbl[i].e_we));
            check("tbl_rvalid", i, 32'(rv_o[0]), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) check("tbl_rdata", i, 32'(rd_o[0]), 32'(tbl[i].e_rd));
            if (tbl[i].c_disp) check("tbl_disp", i, 32'(disp_o[0]), 32'(tbl[i].e_disp));
            at_pos();
        end

        // Burst limit in v-blank: 4 on the small instance, 64 on the default one.
        rst = 1'b1; step(); rst = 1'b0;
        xcount = '{0, 0};
        for (int i = 0; i < 80; i++) begin
            set_in(i, 780, 1, 1, 20'(i), 12'(i), 12'h000);
            at_neg();
            for (int k = 0; k < 2; k++)
                if (gnt_o[k] === 1'b1) xcount[k]++;
            at_pos();
        end
        check("burst_cnt", 0, 32'(xcount[0]), 32'd64);
        check("burst_cnt", 1, 32'(xcount[1]), 32'd4);
        set_in(1340, 805, 1, 1, 20'h0, 12'h0, 12'h000);
        at_neg();
        check("hold_gnt", 1, 32'(gnt_o[1]), 32'd0);
        at_pos();
        set_in(1000, 780, 1, 1, 20'h0, 12'h0, 12'h000);
        step();
        at_neg();
        check("regrant", 1, 32'(gnt_o[1]), 32'd1);
        at_pos();

`ifdef BG_MEM_ARB_STATS_EN
        rst = 1'b1; step(); rst = 1'b0;
        vsync = 1'b0;
        set_in(1023, 100, 1, 1, 20'h0, 12'h0, 12'h000); step();
        for (int i = 1024; i < 1027; i++) begin
            set_in(i, 100, 1, 1, 20'h0, 12'h0, 12'h000); step();
        end
        set_in(1027, 100, 0, 1, 20'h0, 12'h0, 12'h000); step();
        for (int i = 0; i < 9; i++) begin
            set_in(100 + i, 100, 1, 1, 20'h0, 12'h0, 12'h000); step();
        end
        set_in(200, 100, 0, 0, 20'h0, 12'h0, 12'h000);
        vsync = 1'b1; step();
        at_neg();
        check("stall_cnt", 0, 32'(st_o[0]), 32'd10);
        check("xfer_cnt", 0, 32'(xc_o[0]), 32'd3);
        at_pos();
        vsync = 1'b0; step(); step();
        vsync = 1'b1; step();
        at_neg();
        check("stall_clr", 0, 32'(st_o[0]), 32'd0);
        check("xfer_clr", 0, 32'(xc_o[0]), 32'd0);
        at_pos();
        vsync = 1'b0;
`endif

        // Randomized traffic with free-running timing and occasional jumps/resets.
        begin
            int h, v;
            h = 1000; v = 760;
            for (int i = 0; i < 4000; i++) begin
                rst = ($urandom_range(0, 399) == 0);
                if ($urandom_range(0, 63) == 0) h = int'($urandom_range(0, 1343));
                vsync = (v < 3);
                disp_addr = 20'($urandom);
                set_in(h, v, $urandom_range(0, 3) != 0, 1'($urandom), 20'($urandom),
                       12'($urandom), 12'($urandom));
                step();
                h = hnext(h);
                if (h == 0) v = (v == 805) ? 0 : v + 1;
            end
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
